// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester-side and memory-side signal bundle for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_i;
    logic              we0_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [DATA_W-1:0] wdat0_i;
    logic              gnt0_o;
    logic              err0_o;
    logic              rvalid0_o;
    logic [DATA_W-1:0] rdat0_o;

    logic              req1_i;
    logic              we1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdat1_i;
    logic              gnt1_o;
    logic              err1_o;
    logic              rvalid1_o;
    logic [DATA_W-1:0] rdat1_o;

    logic              mem_rd_en_o;
    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wr_dat_o;
    logic [DATA_W-1:0] mem_rd_dat_i;

    modport slave (
        input  req0_i, we0_i, addr0_i, wdat0_i,
        input  req1_i, we1_i, addr1_i, wdat1_i,
        input  mem_rd_dat_i,
        output gnt0_o, err0_o, rvalid0_o, rdat0_o,
        output gnt1_o, err1_o, rvalid1_o, rdat1_o,
        output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_dat_o
    );

    modport master (
        output req0_i, we0_i, addr0_i, wdat0_i,
        output req1_i, we1_i, addr1_i, wdat1_i,
        output mem_rd_dat_i,
        input  gnt0_o, err0_o, rvalid0_o, rdat0_o,
        input  gnt1_o, err1_o, rvalid1_o, rdat1_o,
        input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin two-port arbiter in front of a synchronous data memory.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  wire logic     clk_i,
    input  wire logic     reset_i,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdat0_q, rdat0_d, rdat1_q, rdat1_d;
    logic              mem_rd_en_q, mem_rd_en_d, mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wr_dat_q, mem_wr_dat_d;

    logic              w_req_any;
    logic              w_win;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdat;
    logic              w_misalign;

    // On a tie the port that was not granted last time wins.
    assign w_req_any  = bus.req0_i | bus.req1_i;
    assign w_win      = (bus.req0_i & bus.req1_i) ? ~last_gnt_q : bus.req1_i;
    assign w_sel_we   = w_win ? bus.we1_i   : bus.we0_i;
    assign w_sel_addr = w_win ? bus.addr1_i : bus.addr0_i;
    assign w_sel_wdat = w_win ? bus.wdat1_i : bus.wdat0_i;
    assign w_misalign = (w_sel_addr[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdat0_d      = rdat0_q;
        rdat1_d      = rdat1_q;
        mem_rd_en_d  = 1'b0;
        mem_wr_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wr_dat_d = mem_wr_dat_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (w_req_any) begin
                    state_d    = ST_ISSUE;
                    owner_d    = w_win;
                    last_gnt_d = w_win;
                    gnt0_d     = ~w_win;
                    gnt1_d     = w_win;
                    if (w_misalign) begin
                        err0_d = ~w_win;
                        err1_d = w_win;
                    end else if (w_sel_we) begin
                        mem_wr_en_d  = 1'b1;
                        mem_addr_d   = w_sel_addr;
                        mem_wr_dat_d = w_sel_wdat;
                    end else begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = w_sel_addr;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // The registered read enable tells whether this issue needs a response.
            ST_ISSUE: begin
                if (mem_rd_en_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RD_LATENCY);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    if (owner_q) begin
                        rdat1_d   = bus.mem_rd_dat_i;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdat0_d   = bus.mem_rd_dat_i;
                        rvalid0_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            last_gnt_q   <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdat0_q      <= '0;
            rdat1_q      <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_dat_q <= '0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdat0_q      <= rdat0_d;
            rdat1_q      <= rdat1_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_dat_q <= mem_wr_dat_d;
        end
    end

    assign bus.gnt0_o       = gnt0_q;
    assign bus.gnt1_o       = gnt1_q;
    assign bus.err0_o       = err0_q;
    assign bus.err1_o       = err1_q;
    assign bus.rvalid0_o    = rvalid0_q;
    assign bus.rvalid1_o    = rvalid1_q;
    assign bus.rdat0_o      = rdat0_q;
    assign bus.rdat1_o      = rdat1_q;
    assign bus.mem_rd_en_o  = mem_rd_en_q;
    assign bus.mem_wr_en_o  = mem_wr_en_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wr_dat_o = mem_wr_dat_q;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed bench for dmem_arbiter (RD_LATENCY 1 and 3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) u_dut_a (
        .clk_i   (clk),
        .reset_i (rst_a),
        .bus     (bus_a)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u_dut_b (
        .clk_i   (clk),
        .reset_i (rst_b),
        .bus     (bus_b)
    );

    // Memory A: one-cycle synchronous read.
    logic [31:0] mem_a [16];
    logic [31:0] rd_a_q;
    always @(posedge clk) begin
        if (bus_a.mem_wr_en_o) mem_a[bus_a.mem_addr_o[5:2]] <= bus_a.mem_wr_dat_o;
        if (bus_a.mem_rd_en_o) rd_a_q <= mem_a[bus_a.mem_addr_o[5:2]];
    end
    assign bus_a.mem_rd_dat_i = rd_a_q;

    // Memory B: three-cycle synchronous read.
    logic [31:0] mem_b [16];
    logic [31:0] rd_b_p1, rd_b_p2, rd_b_p3;
    always @(posedge clk) begin
        if (bus_b.mem_wr_en_o) mem_b[bus_b.mem_addr_o[5:2]] <= bus_b.mem_wr_dat_o;
        if (bus_b.mem_rd_en_o) rd_b_p1 <= mem_b[bus_b.mem_addr_o[5:2]];
        rd_b_p2 <= rd_b_p1;
        rd_b_p3 <= rd_b_p2;
    end
    assign bus_b.mem_rd_dat_i = rd_b_p3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_write0(input logic [31:0] ad, input logic [31:0] d);
        bus_a.req0_i  = 1'b1;
        bus_a.we0_i   = 1'b1;
        bus_a.addr0_i = ad;
        bus_a.wdat0_i = d;
        tick();
        bus_a.req0_i  = 1'b0;
        tick();
    endtask

    logic seen;

    initial begin
        bus_a.req0_i = 1'b0; bus_a.we0_i = 1'b0; bus_a.addr0_i = '0; bus_a.wdat0_i = '0;
        bus_a.req1_i = 1'b0; bus_a.we1_i = 1'b0; bus_a.addr1_i = '0; bus_a.wdat1_i = '0;
        bus_b.req0_i = 1'b0; bus_b.we0_i = 1'b0; bus_b.addr0_i = '0; bus_b.wdat0_i = '0;
        bus_b.req1_i = 1'b0; bus_b.we1_i = 1'b0; bus_b.addr1_i = '0; bus_b.wdat1_i = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        check("reset_ctrl", {bus_a.gnt0_o, bus_a.gnt1_o, bus_a.err0_o, bus_a.err1_o,
                             bus_a.rvalid0_o, bus_a.rvalid1_o, bus_a.mem_rd_en_o, bus_a.mem_wr_en_o}, 64'h0);
        check("reset_addr", bus_a.mem_addr_o, 64'h0);
        check("reset_rdat", {bus_a.rdat0_o, bus_a.rdat1_o}, 64'h0);

        // 1: write on port 0
        bus_a.req0_i = 1'b1; bus_a.we0_i = 1'b1; bus_a.addr0_i = 32'h10; bus_a.wdat0_i = 32'hDEADBEEF;
        tick();
        check("s1_gnt", {bus_a.gnt1_o, bus_a.gnt0_o, bus_a.mem_wr_en_o, bus_a.mem_rd_en_o, bus_a.rvalid0_o}, 64'b01100);
        check("s1_addr", bus_a.mem_addr_o, 64'h10);
        check("s1_wdat", bus_a.mem_wr_dat_o, 64'hDEADBEEF);
        bus_a.req0_i = 1'b0;
        tick();
        check("s1_idle", {bus_a.gnt0_o, bus_a.mem_wr_en_o, bus_a.mem_rd_en_o, bus_a.rvalid0_o}, 64'h0);

        // 2: read back on port 1
        bus_a.req1_i = 1'b1; bus_a.we1_i = 1'b0; bus_a.addr1_i = 32'h10;
        tick();
        check("s2_gnt", {bus_a.gnt1_o, bus_a.gnt0_o, bus_a.mem_rd_en_o, bus_a.mem_wr_en_o}, 64'b1010);
        bus_a.req1_i = 1'b0;
        tick();
        check("s2_early", bus_a.rvalid1_o, 64'h0);
        tick();
        check("s2_rvalid", {bus_a.rvalid1_o, bus_a.rvalid0_o}, 64'b10);
        check("s2_rdat", bus_a.rdat1_o, 64'hDEADBEEF);
        tick();
        check("s2_hold", {bus_a.rvalid1_o, bus_a.rdat1_o}, {1'b0, 32'hDEADBEEF});

        // 3: simultaneous reads from reset
        a_write0(32'h0, 32'h11);
        a_write0(32'h4, 32'h22);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.req0_i = 1'b1; bus_a.we0_i = 1'b0; bus_a.addr0_i = 32'h0;
        bus_a.req1_i = 1'b1; bus_a.we1_i = 1'b0; bus_a.addr1_i = 32'h4;
        tick();
        check("s3_gnt0", {bus_a.gnt1_o, bus_a.gnt0_o}, 64'b01);
        bus_a.req0_i = 1'b0;
        tick();
        tick();
        check("s3_rvalid0", {bus_a.rvalid1_o, bus_a.rvalid0_o}, 64'b01);
        check("s3_rdat0", bus_a.rdat0_o, 64'h11);
        tick();
        check("s3_gnt1", {bus_a.gnt1_o, bus_a.gnt0_o}, 64'b10);
        bus_a.req1_i = 1'b0;
        tick();
        tick();
        check("s3_rvalid1", {bus_a.rvalid1_o, bus_a.rvalid0_o}, 64'b10);
        check("s3_rdat1", bus_a.rdat1_o, 64'h22);

        // 4: continuous writes from both ports
        bus_a.req0_i = 1'b1; bus_a.we0_i = 1'b1; bus_a.addr0_i = 32'h20; bus_a.wdat0_i = 32'hA0;
        bus_a.req1_i = 1'b1; bus_a.we1_i = 1'b1; bus_a.addr1_i = 32'h24; bus_a.wdat1_i = 32'hB0;
        for (int i = 1; i <= 8; i++) begin
            logic [1:0] exp_g;
            tick();
            exp_g = (i == 1 || i == 5) ? 2'b01 : ((i == 3 || i == 7) ? 2'b10 : 2'b00);
            check($sformatf("s4_gnt_%0d", i), {bus_a.gnt1_o, bus_a.gnt0_o}, {62'h0, exp_g});
        end
        bus_a.req0_i = 1'b0;
        bus_a.req1_i = 1'b0;
        tick();

        // 5: misaligned read on port 0
        bus_a.req0_i = 1'b1; bus_a.we0_i = 1'b0; bus_a.addr0_i = 32'h13;
        tick();
        check("s5_gnt_err", {bus_a.gnt0_o, bus_a.err0_o, bus_a.mem_rd_en_o, bus_a.mem_wr_en_o}, 64'b1100);
        bus_a.req0_i = 1'b0;
        seen = 1'b0;
        tick();
        seen = seen | bus_a.rvalid0_o;
        check("s5_err_clr", {bus_a.gnt0_o, bus_a.err0_o}, 64'b00);
        bus_a.req1_i = 1'b1; bus_a.we1_i = 1'b1; bus_a.addr1_i = 32'h30; bus_a.wdat1_i = 32'h55;
        tick();
        seen = seen | bus_a.rvalid0_o;
        check("s5_idle_next", {bus_a.gnt1_o, bus_a.err1_o, bus_a.mem_wr_en_o}, 64'b101);
        bus_a.req1_i = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | bus_a.rvalid0_o;
        end
        check("s5_no_rvalid", seen, 64'h0);

        // 6: reset during a pending read on the latency-3 instance
        bus_b.req1_i = 1'b1; bus_b.we1_i = 1'b0; bus_b.addr1_i = 32'h8;
        tick();
        check("s6_gnt", {bus_b.gnt1_o, bus_b.mem_rd_en_o, bus_b.mem_addr_o[7:0]}, {2'b11, 8'h08});
        bus_b.req1_i = 1'b0;
        tick();
        rst_b = 1'b1;
        #1;
        check("s6_async_ctrl", {bus_b.gnt0_o, bus_b.gnt1_o, bus_b.err0_o, bus_b.err1_o,
                                bus_b.rvalid0_o, bus_b.rvalid1_o, bus_b.mem_rd_en_o, bus_b.mem_wr_en_o}, 64'h0);
        check("s6_async_addr", bus_b.mem_addr_o, 64'h0);
        tick();
        tick();
        rst_b = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | bus_b.rvalid1_o;
        end
        check("s6_no_rvalid", seen, 64'h0);
        bus_b.req0_i = 1'b1; bus_b.we0_i = 1'b0; bus_b.addr0_i = 32'h0;
        bus_b.req1_i = 1'b1; bus_b.we1_i = 1'b0; bus_b.addr1_i = 32'h4;
        tick();
        check("s6_tie_port0", {bus_b.gnt1_o, bus_b.gnt0_o}, 64'b01);
        bus_b.req0_i = 1'b0;
        bus_b.req1_i = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
